// File: rtl/junction_safety_monitor_if.sv
// Signal bundle between the junction controller, the safety monitor and the lamp drivers.
// The controller side drives the light codes; the monitor side drives the lamps and fault status.
interface junction_safety_monitor_if;
  logic [1:0] ew_light;
  logic [1:0] ns_light;
  logic       clear_fault;
  logic [2:0] ew_lamp;
  logic [2:0] ns_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_count;

  modport master (
    output ew_light, ns_light, clear_fault,
    input  ew_lamp, ns_lamp, fault, fault_code, fault_count
  );

  modport slave (
    input  ew_light, ns_light, clear_fault,
    output ew_lamp, ns_lamp, fault, fault_code, fault_count
  );
endinterface

// File: rtl/junction_safety_monitor.sv
// Monitors the two junction light codes for unsafe behaviour and drives the lamps.
// Any violation latches a fault and flashes both directions red until acknowledged.
module junction_safety_monitor #(
  parameter int HOLD_MAX   = 16,
  parameter int FLASH_HALF = 4
) (
  input logic                       clk,
  input logic                       rstb,
  junction_safety_monitor_if.slave  bus
);

  typedef enum logic [1:0] {S_INIT, S_MONITOR, S_FAULT} state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] CODE_CONFLICT = 3'b001;
  localparam logic [2:0] CODE_ILLEGAL  = 3'b010;
  localparam logic [2:0] CODE_STEP     = 3'b011;
  localparam logic [2:0] CODE_TIMEOUT  = 3'b100;
  localparam logic [7:0] HOLD_LIM   = 8'(HOLD_MAX);
  localparam logic [8:0] FLASH_H    = 9'(FLASH_HALF);
  localparam logic [8:0] FLASH_LAST = 9'(2 * FLASH_HALF - 1);

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      2'b00:   decode = 3'b100;
      2'b01:   decode = 3'b010;
      2'b10:   decode = 3'b001;
      default: decode = 3'b000;
    endcase
  endfunction

  function automatic logic illegal_step(input logic [1:0] prev, input logic [1:0] cur);
    illegal_step = ((prev == 2'b00) && (cur == 2'b10)) || ((prev == 2'b10) && (cur == 2'b00));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Length of the current yellow/green run including this cycle; zero on red or illegal code.
  function automatic logic [7:0] hold_run(input logic [1:0] prev, input logic [1:0] cur,
                                          input logic [7:0] cnt);
    if ((cur == 2'b01) || (cur == 2'b10))
      hold_run = (cur == prev) ? sat_inc8(cnt) : 8'd1;
    else
      hold_run = 8'd0;
  endfunction

  state_t     state, state_nxt;
  logic [1:0] ew_prev, ns_prev, ew_prev_nxt, ns_prev_nxt;
  logic [7:0] ew_hold, ns_hold, ew_hold_nxt, ns_hold_nxt;
  logic [7:0] ew_run, ns_run;
  logic [8:0] flash, flash_nxt;
  logic [2:0] ew_lamp, ns_lamp, ew_lamp_nxt, ns_lamp_nxt;
  logic [2:0] code, code_nxt;
  logic [3:0] count, count_nxt;
  logic       conflict, bad_code, bad_step, timeout;

  assign conflict = (bus.ew_light != 2'b00) && (bus.ns_light != 2'b00);
  assign bad_code = (bus.ew_light == 2'b11) || (bus.ns_light == 2'b11);
  assign bad_step = illegal_step(ew_prev, bus.ew_light) || illegal_step(ns_prev, bus.ns_light);
  assign ew_run   = hold_run(ew_prev, bus.ew_light, ew_hold);
  assign ns_run   = hold_run(ns_prev, bus.ns_light, ns_hold);
  assign timeout  = (ew_run >= HOLD_LIM) || (ns_run >= HOLD_LIM);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= S_INIT;
      ew_prev <= 2'b00;
      ns_prev <= 2'b00;
      ew_hold <= 8'd0;
      ns_hold <= 8'd0;
      flash   <= 9'd0;
      ew_lamp <= LAMP_R;
      ns_lamp <= LAMP_R;
      code    <= 3'b000;
      count   <= 4'd0;
    end else begin
      state   <= state_nxt;
      ew_prev <= ew_prev_nxt;
      ns_prev <= ns_prev_nxt;
      ew_hold <= ew_hold_nxt;
      ns_hold <= ns_hold_nxt;
      flash   <= flash_nxt;
      ew_lamp <= ew_lamp_nxt;
      ns_lamp <= ns_lamp_nxt;
      code    <= code_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ew_prev_nxt = bus.ew_light;
    ns_prev_nxt = bus.ns_light;
    ew_hold_nxt = 8'd0;
    ns_hold_nxt = 8'd0;
    flash_nxt   = 9'd0;
    ew_lamp_nxt = LAMP_R;
    ns_lamp_nxt = LAMP_R;
    code_nxt    = code;
    count_nxt   = count;
    case (state)
      S_INIT: begin
        if ((bus.ew_light == 2'b00) && (bus.ns_light == 2'b00))
          state_nxt = S_MONITOR;
      end
      S_MONITOR: begin
        if (conflict || bad_code || bad_step || timeout) begin
          state_nxt = S_FAULT;
          count_nxt = sat_inc4(count);
          if (conflict)      code_nxt = CODE_CONFLICT;
          else if (bad_code) code_nxt = CODE_ILLEGAL;
          else if (bad_step) code_nxt = CODE_STEP;
          else               code_nxt = CODE_TIMEOUT;
        end else begin
          ew_lamp_nxt = decode(bus.ew_light);
          ns_lamp_nxt = decode(bus.ns_light);
          ew_hold_nxt = ew_run;
          ns_hold_nxt = ns_run;
        end
      end
      default: begin
        // Previous values are parked at red so INIT restarts from a clean history.
        ew_prev_nxt = 2'b00;
        ns_prev_nxt = 2'b00;
        if (bus.clear_fault) begin
          state_nxt = S_INIT;
        end else begin
          flash_nxt   = (flash == FLASH_LAST) ? 9'd0 : flash + 9'd1;
          ew_lamp_nxt = (flash_nxt < FLASH_H) ? LAMP_R : LAMP_OFF;
          ns_lamp_nxt = (flash_nxt < FLASH_H) ? LAMP_R : LAMP_OFF;
        end
      end
    endcase
  end

  assign bus.ew_lamp     = ew_lamp;
  assign bus.ns_lamp     = ns_lamp;
  assign bus.fault       = (state == S_FAULT);
  assign bus.fault_code  = code;
  assign bus.fault_count = count;

endmodule

// File: tb/tb_junction_safety_monitor.sv
// Bench for junction_safety_monitor: a vector table for the main sequences plus
// hand-written hold-timeout, saturation and asynchronous-reset sequences.
module tb_junction_safety_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  typedef struct packed {
    logic [2:0] el;
    logic [2:0] nl;
    logic       f;
    logic [2:0] code;
    logic [3:0] cnt;
  } out_t;

  typedef struct {
    string      name;
    logic [1:0] ew;
    logic [1:0] ns;
    logic       clr;
    out_t       exp;
  } vec_t;

  logic clk;
  logic rstb;
  int   n_vec;
  int   n_bad;
  out_t exp_q[$];
  vec_t tbl[$];

  junction_safety_monitor_if bus();

  junction_safety_monitor #(.HOLD_MAX(16), .FLASH_HALF(4)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(logic [2:0] el, logic [2:0] nl, logic f, logic [2:0] code,
                              logic [3:0] cnt);
    out_t o;
    o.el = el; o.nl = nl; o.f = f; o.code = code; o.cnt = cnt;
    return o;
  endfunction

  task automatic add(string nm, logic [1:0] ew, logic [1:0] ns, logic clr, out_t e);
    vec_t v;
    v.name = nm; v.ew = ew; v.ns = ns; v.clr = clr; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic compare(string nm, out_t e);
    out_t a;
    a = {bus.ew_lamp, bus.ns_lamp, bus.fault, bus.fault_code, bus.fault_count};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got ew=%b ns=%b fault=%b code=%b count=%0d, want ew=%b ns=%b fault=%b code=%b count=%0d",
               nm, a.el, a.nl, a.f, a.code, a.cnt, e.el, e.nl, e.f, e.code, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expected registered outputs, check after the edge.
  task automatic step(string nm, logic [1:0] ew, logic [1:0] ns, logic clr, out_t e);
    bus.ew_light    = ew;
    bus.ns_light    = ns;
    bus.clear_fault = clr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(nm, exp_q.pop_front());
  endtask

  initial begin
    logic [2:0] ecode;
    logic [3:0] ecnt;
    n_vec = 0;
    n_bad = 0;
    rstb = 1'b0;
    bus.ew_light = 2'b00;
    bus.ns_light = 2'b00;
    bus.clear_fault = 1'b0;

    add("init_to_mon", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd0, 4'd0));
    for (int i = 0; i < 3; i++) add("mon_red",    2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd0, 4'd0));
    for (int i = 0; i < 3; i++) add("mon_yellow", 2'b01, 2'b00, 1'b0, mk(Y, R, 0, 3'd0, 4'd0));
    for (int i = 0; i < 3; i++) add("mon_green",  2'b10, 2'b00, 1'b0, mk(G, R, 0, 3'd0, 4'd0));
    for (int i = 0; i < 3; i++) add("mon_yellow2", 2'b01, 2'b00, 1'b0, mk(Y, R, 0, 3'd0, 4'd0));
    for (int i = 0; i < 3; i++) add("mon_red2",   2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd0, 4'd0));
    add("clr_in_mon", 2'b00, 2'b01, 1'b1, mk(R, Y, 0, 3'd0, 4'd0));
    add("ns_back_red", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd0, 4'd0));
    add("conflict",   2'b10, 2'b01, 1'b0, mk(R, R, 1, 3'd1, 4'd1));
    for (int i = 1; i < 4; i++) add("flash_on",  2'b00, 2'b00, 1'b0, mk(R, R, 1, 3'd1, 4'd1));
    for (int i = 4; i < 8; i++) add("flash_off", 2'b00, 2'b00, 1'b0, mk(O, O, 1, 3'd1, 4'd1));
    add("flash_wrap", 2'b00, 2'b00, 1'b0, mk(R, R, 1, 3'd1, 4'd1));
    add("clear",      2'b00, 2'b01, 1'b1, mk(R, R, 0, 3'd1, 4'd1));
    add("init_hold",  2'b00, 2'b01, 1'b0, mk(R, R, 0, 3'd1, 4'd1));
    add("init_hold2", 2'b01, 2'b00, 1'b0, mk(R, R, 0, 3'd1, 4'd1));
    add("init_to_mon2", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd1, 4'd1));
    add("bad_step",   2'b10, 2'b00, 1'b0, mk(R, R, 1, 3'd3, 4'd2));
    add("clear2",     2'b00, 2'b01, 1'b1, mk(R, R, 0, 3'd3, 4'd2));
    add("init_hold3", 2'b00, 2'b01, 1'b0, mk(R, R, 0, 3'd3, 4'd2));
    add("init_to_mon3", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd3, 4'd2));
    add("mon_ns_yel", 2'b00, 2'b01, 1'b0, mk(R, Y, 0, 3'd3, 4'd2));
    add("mon_ns_red", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd3, 4'd2));

    #12;
    compare("reset_state", mk(R, R, 0, 3'd0, 4'd0));
    @(negedge clk);
    rstb = 1'b1;

    foreach (tbl[i]) step(tbl[i].name, tbl[i].ew, tbl[i].ns, tbl[i].clr, tbl[i].exp);

    // Green held 15 cycles then back to yellow: no timeout.
    step("hold15_y", 2'b01, 2'b00, 1'b0, mk(Y, R, 0, 3'd3, 4'd2));
    for (int i = 0; i < 15; i++) step("hold15_g", 2'b10, 2'b00, 1'b0, mk(G, R, 0, 3'd3, 4'd2));
    step("hold15_back_y", 2'b01, 2'b00, 1'b0, mk(Y, R, 0, 3'd3, 4'd2));
    step("hold15_red", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd3, 4'd2));

    // Green held 16 cycles: timeout.
    step("hold16_y", 2'b01, 2'b00, 1'b0, mk(Y, R, 0, 3'd3, 4'd2));
    for (int i = 0; i < 15; i++) step("hold16_g", 2'b10, 2'b00, 1'b0, mk(G, R, 0, 3'd3, 4'd2));
    step("hold_timeout", 2'b10, 2'b00, 1'b0, mk(R, R, 1, 3'd4, 4'd3));
    step("timeout_clear", 2'b00, 2'b00, 1'b1, mk(R, R, 0, 3'd4, 4'd3));
    step("timeout_reinit", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd4, 4'd3));

    // Conflict outranks illegal code; then repeat faults until the count saturates.
    step("prio_conflict", 2'b11, 2'b10, 1'b0, mk(R, R, 1, 3'd1, 4'd4));
    ecode = 3'd1;
    ecnt  = 4'd4;
    for (int i = 0; i < 15; i++) begin
      step("sat_clear", 2'b00, 2'b00, 1'b1, mk(R, R, 0, ecode, ecnt));
      step("sat_reinit", 2'b00, 2'b00, 1'b0, mk(R, R, 0, ecode, ecnt));
      ecode = 3'd2;
      if (ecnt != 4'd15) ecnt = ecnt + 4'd1;
      step("sat_illegal", 2'b11, 2'b00, 1'b0, mk(R, R, 1, ecode, ecnt));
    end

    // Asynchronous reset in the middle of a fault.
    step("fault_c1", 2'b00, 2'b00, 1'b0, mk(R, R, 1, 3'd2, 4'd15));
    step("fault_c2", 2'b00, 2'b00, 1'b0, mk(R, R, 1, 3'd2, 4'd15));
    #3;
    rstb = 1'b0;
    #1;
    compare("async_reset", mk(R, R, 0, 3'd0, 4'd0));
    @(negedge clk);
    rstb = 1'b1;
    step("post_rst_init", 2'b00, 2'b00, 1'b0, mk(R, R, 0, 3'd0, 4'd0));
    step("post_rst_mon", 2'b01, 2'b00, 1'b0, mk(Y, R, 0, 3'd0, 4'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/junction_safety_monitor.md
JUNCTION_SAFETY_MONITOR -- requirements
Module: junction_safety_monitor

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum consecutive cycles a direction may hold yellow or green; legal range 2..255.
REQ-002 Parameter FLASH_HALF, default 4: half-period in cycles of the fault-mode red flash; legal range 1..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstb  input  1  asynchronous, active-low reset.
REQ-005 ew_light  input  2  EW light code from junction controller: 00 red, 01 yellow, 10 green, 11 illegal.
REQ-006 ns_light  input  2  NS light code, same encoding as ew_light.
REQ-007 clear_fault  input  1  single-cycle fault acknowledge; ignored outside FAULT.
REQ-008 ew_lamp  output  3  registered one-hot EW lamp drive {R,Y,G}; 000 means all lamps off.
REQ-009 ns_lamp  output  3  registered one-hot NS lamp drive {R,Y,G}.
REQ-010 fault  output  1  high while in FAULT state.
REQ-011 fault_code  output  3  cause of the latest fault: 000 none, 001 conflict, 010 illegal code, 011 illegal transition, 100 hold timeout.
REQ-012 fault_count  output  4  number of faults entered since reset; saturates at 15.

Function
REQ-013 State machine SHALL have three states: INIT, MONITOR, FAULT.
REQ-014 INIT: both lamps 100 (red). Move to MONITOR on the first cycle where ew_light==00 and ns_light==00.
REQ-015 MONITOR: each lamp SHALL be the one-hot decode of the corresponding input code, registered, with 1-cycle latency.
REQ-016 Conflict: both inputs non-00 in the same cycle.
REQ-017 Illegal code: either input ==11.
REQ-018 Illegal transition: either input changes R->G or G->R relative to its value in the previous cycle.
  - Legal: hold, R->Y, Y->G, G->Y, Y->R.
REQ-019 Hold timeout: a per-direction 8-bit counter counts consecutive cycles in which the code is 01 or 10 and unchanged.
  - The counter clears on any code change or on red.
  - Timeout fires when the count reaches HOLD_MAX.
REQ-020 Previous-value registers SHALL update every cycle in INIT and MONITOR. They SHALL load 00 on reset and on FAULT exit.
REQ-021 On detection in MONITOR, the next cycle SHALL show: state=FAULT, fault=1, fault_code latched, fault_count incremented (saturating).
REQ-022 Simultaneous faults SHALL report one code, priority conflict > illegal code > illegal transition > hold timeout; fault_count SHALL increment by one.
REQ-023 Detection SHALL be inactive in INIT and FAULT.
REQ-024 FAULT: ew_lamp and ns_lamp SHALL both be 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating, starting with 100 on the first FAULT cycle.
REQ-025 FAULT -> INIT on clear_fault=1.
  - The next cycle SHALL show fault=0; fault_code holds its value until the next fault.
  - The flash counter and hold counters SHALL clear.
REQ-026 Exiting FAULT SHALL NOT pass through MONITOR; INIT SHALL again require both inputs red.
REQ-027 clear_fault high in INIT or MONITOR SHALL have no effect.

Reset
REQ-028 rstb=0 SHALL force, asynchronously, from any state including mid-FAULT:
  - state=INIT
  - ew_lamp=ns_lamp=100
  - fault=0, fault_code=000, fault_count=0
  - hold, flash and previous-value registers cleared
REQ-029 After rstb deasserts, the first rising edge SHALL evaluate INIT normally.

Verification
REQ-030 Reset, both inputs 00 -> MONITOR after 1 cycle. Then drive EW R->Y->G->Y->R, 3 cycles each -> ew_lamp follows 100,010,001,010,100 one cycle late; fault stays 0.
REQ-031 In MONITOR, drive ew_light=10 and ns_light=01 together -> next cycle fault=1, fault_code=001, fault_count=1, lamps 100 for 4 cycles then 000 for 4 cycles (defaults).
REQ-032 In MONITOR, ew_light 00->10 directly -> fault_code=011. Pulse clear_fault with ns_light=01 -> INIT, lamps 100, stays in INIT until both inputs 00.
REQ-033 In MONITOR, hold ew_light=10 for 16 cycles -> fault_code=100 on the next cycle. Holding it for 15 cycles then changing to 01 -> no fault.
REQ-034 In one cycle, ew_light=11 and ns_light=10 -> fault_code=001 (priority), fault_count increments by 1. Repeat 16 fault/clear cycles -> fault_count saturates at 15.
REQ-035 Assert rstb=0 mid-FAULT, between clock edges -> immediately fault=0, fault_code=000, fault_count=0, lamps 100.
